// File: rtl/branch_pc_unit.sv
// Program counter and branch resolution for the KGP miniRISC datapath.
// Holds PC and carry flag. Selects sequential, PC-relative or register-indirect next PC on each commit.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [2:0]  CondJump,
    input  logic        UncondJump,
    input  logic [1:0]  AddrSel,
    input  logic [25:0] imm26,
    input  logic [15:0] imm16,
    input  logic [31:0] rs_data,
    input  logic        carry_in,
    input  logic        carry_we,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        carry_flag,
    output logic        branch_taken,
    output logic        align_err
);

    logic [31:0] pc_q, pc_d;
    logic        carry_q, carry_d;
    logic        taken_q, taken_d;
    logic        align_q, align_d;

    logic [31:0] off26, off16, target, next_pc;
    logic        cond, taken, misalign;

    assign pc_plus4 = pc_q + 32'd4;
    assign off26    = {{4{imm26[25]}}, imm26, 2'b00};
    assign off16    = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target = pc_plus4;
        case (AddrSel)
            2'b00:   target = pc_q + off26;
            2'b01:   target = {rs_data[31:2], 2'b00};
            2'b10:   target = pc_q + off16;
            default: target = pc_plus4;
        endcase
    end

    // Carry conditions read the stored flag, never the same-cycle carry_in.
    always_comb begin
        cond = 1'b0;
        case (CondJump)
            3'b001:  cond = rs_data[31];
            3'b010:  cond = (rs_data == 32'd0);
            3'b011:  cond = (rs_data != 32'd0);
            3'b100:  cond = carry_q;
            3'b101:  cond = ~carry_q;
            default: cond = 1'b0;
        endcase
    end

    assign taken    = UncondJump | cond;
    assign next_pc  = taken ? target : pc_plus4;
    assign misalign = taken && (AddrSel == 2'b01) && (rs_data[1:0] != 2'b00);

    always_comb begin
        pc_d    = pc_q;
        carry_d = carry_q;
        taken_d = 1'b0;
        align_d = align_q;
        if (en) begin
            pc_d    = next_pc;
            taken_d = taken;
            align_d = align_q | misalign;
            if (carry_we) begin
                carry_d = carry_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            carry_q <= 1'b0;
            taken_q <= 1'b0;
            align_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            carry_q <= carry_d;
            taken_q <= taken_d;
            align_q <= align_d;
        end
    end

    assign pc           = pc_q;
    assign carry_flag   = carry_q;
    assign branch_taken = taken_q;
    assign align_err    = align_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit with hand-computed expected PC, carry and flag values.
module tb_branch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [2:0]  CondJump;
    logic        UncondJump;
    logic [1:0]  AddrSel;
    logic [25:0] imm26;
    logic [15:0] imm16;
    logic [31:0] rs_data;
    logic        carry_in;
    logic        carry_we;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        carry_flag;
    logic        branch_taken;
    logic        align_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .en(en),
        .CondJump(CondJump), .UncondJump(UncondJump), .AddrSel(AddrSel),
        .imm26(imm26), .imm16(imm16), .rs_data(rs_data),
        .carry_in(carry_in), .carry_we(carry_we),
        .pc(pc), .pc_plus4(pc_plus4), .carry_flag(carry_flag),
        .branch_taken(branch_taken), .align_err(align_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then sample 1ns after the rising edge.
    task automatic step(input logic r, input logic e, input logic [2:0] cj, input logic uj,
                        input logic [1:0] as, input logic [25:0] i26, input logic [15:0] i16,
                        input logic [31:0] rs, input logic cin, input logic cwe);
        @(negedge clk);
        rst = r; en = e; CondJump = cj; UncondJump = uj; AddrSel = as;
        imm26 = i26; imm16 = i16; rs_data = rs; carry_in = cin; carry_we = cwe;
        @(posedge clk);
        #1;
    endtask

    task automatic seq_step();
        step(1'b0, 1'b1, 3'b000, 1'b0, 2'b00, 26'd0, 16'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic br_step(input logic [31:0] rs);
        step(1'b0, 1'b1, 3'b000, 1'b1, 2'b01, 26'd0, 16'd0, rs, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset wins over a simultaneous taken branch.
        step(1'b1, 1'b1, 3'b000, 1'b1, 2'b00, 26'd5, 16'd0, 32'd0, 1'b1, 1'b1);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_carry", {31'd0, carry_flag}, 32'd0);
        chk("rst_taken", {31'd0, branch_taken}, 32'd0);
        chk("rst_align", {31'd0, align_err}, 32'd0);

        seq_step();
        chk("seq_pc4", pc, 32'h4);
        chk("seq_taken4", {31'd0, branch_taken}, 32'd0);
        seq_step();
        chk("seq_pc8", pc, 32'h8);
        seq_step();
        chk("seq_pcC", pc, 32'hC);
        chk("seq_takenC", {31'd0, branch_taken}, 32'd0);

        br_step(32'h100);
        chk("br_pc100", pc, 32'h100);
        chk("br_taken100", {31'd0, branch_taken}, 32'd1);
        step(1'b0, 1'b1, 3'b000, 1'b1, 2'b00, 26'h3FFFFFE, 16'd0, 32'd0, 1'b0, 1'b0);
        chk("jmp_neg_pc", pc, 32'hF8);
        chk("jmp_neg_taken", {31'd0, branch_taken}, 32'd1);
        seq_step();
        chk("jmp_after_pc", pc, 32'hFC);
        chk("jmp_pulse_end", {31'd0, branch_taken}, 32'd0);

        br_step(32'hFFFF_FFFC);
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4, 32'h0);
        seq_step();
        chk("wrap_next", pc, 32'h0);

        br_step(32'h40);
        step(1'b0, 1'b1, 3'b010, 1'b0, 2'b10, 26'd0, 16'h0004, 32'h0, 1'b0, 1'b0);
        chk("bz_taken_pc", pc, 32'h50);
        chk("bz_taken_flag", {31'd0, branch_taken}, 32'd1);
        br_step(32'h40);
        step(1'b0, 1'b1, 3'b001, 1'b0, 2'b10, 26'd0, 16'h0004, 32'h5, 1'b0, 1'b0);
        chk("bltz_nt_pc", pc, 32'h44);
        chk("bltz_nt_flag", {31'd0, branch_taken}, 32'd0);
        br_step(32'h40);
        step(1'b0, 1'b1, 3'b011, 1'b0, 2'b10, 26'd0, 16'h0004, 32'h8000_0000, 1'b0, 1'b0);
        chk("bnz_taken_pc", pc, 32'h50);
        br_step(32'h40);
        step(1'b0, 1'b1, 3'b001, 1'b0, 2'b10, 26'd0, 16'h0004, 32'h8000_0000, 1'b0, 1'b0);
        chk("bltz_taken_pc", pc, 32'h50);
        step(1'b0, 1'b1, 3'b011, 1'b0, 2'b10, 26'd0, 16'hFFFF, 32'h1, 1'b0, 1'b0);
        chk("bnz_back_pc", pc, 32'h4C);
        step(1'b0, 1'b1, 3'b010, 1'b0, 2'b10, 26'd0, 16'h0004, 32'h1, 1'b0, 1'b0);
        chk("bz_nt_pc", pc, 32'h50);
        step(1'b0, 1'b1, 3'b110, 1'b0, 2'b10, 26'd0, 16'h0004, 32'h0, 1'b0, 1'b0);
        chk("cond110_nt_pc", pc, 32'h54);

        step(1'b0, 1'b1, 3'b000, 1'b0, 2'b00, 26'd0, 16'd0, 32'd0, 1'b1, 1'b1);
        chk("carry_set", {31'd0, carry_flag}, 32'd1);
        br_step(32'h20);
        chk("carry_hold_br", {31'd0, carry_flag}, 32'd1);
        step(1'b0, 1'b1, 3'b100, 1'b0, 2'b00, 26'd3, 16'd0, 32'd0, 1'b0, 1'b1);
        chk("bcy_old_carry_pc", pc, 32'h2C);
        chk("bcy_carry_cleared", {31'd0, carry_flag}, 32'd0);
        step(1'b0, 1'b1, 3'b101, 1'b0, 2'b00, 26'd3, 16'd0, 32'd0, 1'b0, 1'b0);
        chk("bncy_taken_pc", pc, 32'h38);
        step(1'b0, 1'b1, 3'b100, 1'b0, 2'b00, 26'd3, 16'd0, 32'd0, 1'b0, 1'b0);
        chk("bcy_nt_pc", pc, 32'h3C);

        br_step(32'h1234);
        chk("br_aligned_pc", pc, 32'h1234);
        chk("br_aligned_err", {31'd0, align_err}, 32'd0);
        br_step(32'h2002);
        chk("br_misalign_pc", pc, 32'h2000);
        chk("br_misalign_err", {31'd0, align_err}, 32'd1);
        seq_step();
        chk("align_sticky_pc", pc, 32'h2004);
        chk("align_sticky", {31'd0, align_err}, 32'd1);
        step(1'b0, 1'b1, 3'b000, 1'b1, 2'b11, 26'd7, 16'd7, 32'h0, 1'b0, 1'b0);
        chk("rsvd_sel_pc", pc, 32'h2008);
        chk("rsvd_sel_taken", {31'd0, branch_taken}, 32'd1);

        // Stall: a pending jump and carry write must be ignored.
        step(1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 26'd8, 16'd0, 32'd0, 1'b1, 1'b1);
        chk("stall1_pc", pc, 32'h2008);
        chk("stall1_taken", {31'd0, branch_taken}, 32'd0);
        chk("stall1_carry", {31'd0, carry_flag}, 32'd0);
        step(1'b0, 1'b0, 3'b000, 1'b1, 2'b00, 26'd8, 16'd0, 32'd0, 1'b1, 1'b1);
        chk("stall2_pc", pc, 32'h2008);
        chk("stall2_align", {31'd0, align_err}, 32'd1);

        step(1'b0, 1'b1, 3'b000, 1'b0, 2'b00, 26'd0, 16'd0, 32'd0, 1'b1, 1'b1);
        chk("pre_rst_pc", pc, 32'h200C);
        chk("pre_rst_carry", {31'd0, carry_flag}, 32'd1);
        step(1'b1, 1'b1, 3'b000, 1'b1, 2'b00, 26'd8, 16'd0, 32'd0, 1'b1, 1'b1);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_carry", {31'd0, carry_flag}, 32'd0);
        chk("mid_rst_taken", {31'd0, branch_taken}, 32'd0);
        chk("mid_rst_align", {31'd0, align_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
